decode_hazard_ctrl: RTL

//  Scoreboard-based issue controller between the decode stage and execute.

---
 rtl/riscv_hazard_pkg.sv | 18 +
 rtl/hazard_pend_counter.sv | 46 ++++
 rtl/decode_hazard_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/riscv_hazard_pkg.sv
// Shared constants and types for the decode-stage register scoreboard.
package riscv_hazard_pkg;

    localparam int NUM_REGS    = 32;
    localparam int REG_IDX_W   = $clog2(NUM_REGS);
    localparam int PEND_W      = 2;
    localparam int STALL_CNT_W = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [PEND_W-1:0]    pend_cnt_t;

    localparam pend_cnt_t PEND_MAX = {PEND_W{1'b1}};

    function automatic logic is_x0(input reg_idx_t idx);
        return (idx == reg_idx_t'(0));
    endfunction

endpackage

// File: rtl/hazard_pend_counter.sv
// Outstanding-write counter for one architectural register.
// Callers never raise inc at saturation; dec on an empty counter is dropped.
module hazard_pend_counter
    import riscv_hazard_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      clr,
    input  logic      inc,
    input  logic      dec,
    output pend_cnt_t cnt,
    output logic      nonzero,
    output logic      sat
);

    pend_cnt_t cnt_q;
    pend_cnt_t cnt_d;

    // Next count: clear beats inc/dec, simultaneous inc and dec cancel.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            cnt_d = cnt_q + pend_cnt_t'(1);
        end else if (dec && !inc && (cnt_q != pend_cnt_t'(0))) begin
            cnt_d = cnt_q - pend_cnt_t'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign nonzero = (cnt_q != pend_cnt_t'(0));
    assign sat     = (cnt_q == PEND_MAX);

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Scoreboard issue controller between decode and execute.
// Optional feature macro: DECODE_HAZARD_WB_BYPASS_EN (same-cycle writeback bypass of sources).
module decode_hazard_ctrl
    import riscv_hazard_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dec_valid,
    input  reg_idx_t               dec_rs1,
    input  reg_idx_t               dec_rs2,
    input  reg_idx_t               dec_rd,
    input  logic                   dec_uses_rs1,
    input  logic                   dec_uses_rs2,
    input  logic                   dec_writes_rd,
    output logic                   dec_ready,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    input  logic                   wb_en,
    input  reg_idx_t               wb_rd,
    input  logic                   flush,
    output logic                   busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    pend_cnt_t             pend [NUM_REGS];
    logic [NUM_REGS-1:0]   pend_nz;
    logic [NUM_REGS-1:0]   pend_sat;
    logic [NUM_REGS-1:0]   inc_vec;
    logic [NUM_REGS-1:0]   dec_vec;

    logic                  rs1_haz;
    logic                  rs2_haz;
    logic                  rd_haz;
    logic                  hazard;
    logic                  rs1_byp;
    logic                  rs2_byp;
    logic                  fire_wr;

    logic [STALL_CNT_W-1:0] stall_cycles_q;
    logic [STALL_CNT_W-1:0] stall_cycles_d;

    // x0 is hardwired, so it never has a pending write.
    assign pend[0]     = '0;
    assign pend_nz[0]  = 1'b0;
    assign pend_sat[0] = 1'b0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_pend
            hazard_pend_counter u_cnt (
                .clk     (clk),
                .reset   (reset),
                .clr     (flush),
                .inc     (inc_vec[g]),
                .dec     (dec_vec[g]),
                .cnt     (pend[g]),
                .nonzero (pend_nz[g]),
                .sat     (pend_sat[g])
            );
        end
    endgenerate

    // Same-cycle writeback only clears a source whose last outstanding write is landing.
    always_comb begin
`ifdef DECODE_HAZARD_WB_BYPASS_EN
        rs1_byp = wb_en && (wb_rd == dec_rs1) && (pend[dec_rs1] == pend_cnt_t'(1));
        rs2_byp = wb_en && (wb_rd == dec_rs2) && (pend[dec_rs2] == pend_cnt_t'(1));
`else
        rs1_byp = 1'b0;
        rs2_byp = 1'b0;
`endif
    end

    // Hazard detection and issue handshake.
    always_comb begin
        rs1_haz = dec_uses_rs1 && !is_x0(dec_rs1)
                  && (pend[dec_rs1] != pend_cnt_t'(0)) && !rs1_byp;
        rs2_haz = dec_uses_rs2 && !is_x0(dec_rs2)
                  && (pend[dec_rs2] != pend_cnt_t'(0)) && !rs2_byp;
        rd_haz  = dec_writes_rd && !is_x0(dec_rd) && pend_sat[dec_rd];
        hazard  = rs1_haz || rs2_haz || rd_haz;

        issue_valid = dec_valid && !hazard && !flush;
        dec_ready   = issue_valid && issue_ready;
        fire_wr     = dec_ready && dec_writes_rd && !is_x0(dec_rd);
    end

    // Per-register increment/decrement strobes; flush masks writeback.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            inc_vec[i] = fire_wr && (dec_rd == reg_idx_t'(i));
            dec_vec[i] = wb_en && !flush && (wb_rd == reg_idx_t'(i));
        end
    end

    // Stall performance counter, wrapping naturally.
    always_comb begin
        if (dec_valid && hazard && !flush) begin
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign busy         = |pend_nz;
    assign stall_cycles = stall_cycles_q;

endmodule
